// File: rtl/paint_pkg.sv
// rtl/paint_pkg.sv - shared paint constants, sync pattern and command FSM states
package paint_pkg;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    localparam logic [1:0] SYNC_PAT = 2'b10;

    typedef enum logic [1:0] {
        HDR = 2'd0,
        XLO = 2'd1,
        YHI = 2'd2,
        YLO = 2'd3
    } rx_state_t;
endpackage

// File: rtl/paint_cmd_rx_spi_sync.sv
// rtl/paint_cmd_rx_spi_sync.sv - 2-flop synchronizers for SPI pins plus sck and cs_n rise detection
module spi_sync (
    input  logic clk,
    input  logic reset,
    input  logic sck,
    input  logic sdi,
    input  logic cs_n,
    output logic sck_rise,
    output logic sdi_s,
    output logic cs_n_s,
    output logic cs_rise
);
    logic [1:0] sck_q;
    logic [1:0] sdi_q;
    logic [1:0] cs_q;
    logic       sck_d;
    logic       cs_d;

    // cs_n stages reset high so a held-low chip select never looks like a rising edge
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_q <= 2'b00;
            sdi_q <= 2'b00;
            cs_q  <= 2'b11;
            sck_d <= 1'b0;
            cs_d  <= 1'b1;
        end else begin
            sck_q <= {sck_q[0], sck};
            sdi_q <= {sdi_q[0], sdi};
            cs_q  <= {cs_q[0], cs_n};
            sck_d <= sck_q[1];
            cs_d  <= cs_q[1];
        end
    end

    assign sck_rise = sck_q[1] & ~sck_d;
    assign sdi_s    = sdi_q[1];
    assign cs_n_s   = cs_q[1];
    assign cs_rise  = cs_q[1] & ~cs_d;
endmodule

// File: rtl/paint_cmd_rx.sv
// rtl/paint_cmd_rx.sv - SPI paint command receiver: byte assembly, packet FSM and pixel-write commit
module paint_cmd_rx
    import paint_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sck,
    input  logic       sdi,
    input  logic       cs_n,
    output logic       we,
    output logic [9:0] wx,
    output logic [9:0] wy,
    output logic       brush,
    output logic [2:0] newColor,
    output logic [7:0] err_cnt
);
    localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
    localparam logic [10:0] V_LIM = 11'(V_ACTIVE);

    logic       sck_rise, sdi_s, cs_n_s, cs_rise;
    rx_state_t  state, state_nxt;
    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic [7:0] byte_in;
    logic       bit_en, byte_done;
    logic       hdr_brush;
    logic [2:0] hdr_color;
    logic [1:0] x_hi, y_hi;
    logic [7:0] x_lo;
    logic       bad;
    logic [9:0] x_full, y_full;
    logic       commit, err_inc;

    spi_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .sck      (sck),
        .sdi      (sdi),
        .cs_n     (cs_n),
        .sck_rise (sck_rise),
        .sdi_s    (sdi_s),
        .cs_n_s   (cs_n_s),
        .cs_rise  (cs_rise)
    );

    assign bit_en    = sck_rise & ~cs_n_s;
    assign byte_in   = {shreg, sdi_s};
    assign byte_done = bit_en && (bit_cnt == 3'd7);
    assign x_full    = {x_hi, x_lo};
    assign y_full    = {y_hi, byte_in};

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        err_inc   = 1'b0;
        if (cs_rise) begin
            state_nxt = HDR;
        end else if (byte_done) begin
            case (state)
                HDR: begin
                    if (byte_in[7:6] == SYNC_PAT) state_nxt = XLO;
                    else                          err_inc   = 1'b1;
                end
                XLO: state_nxt = YHI;
                YHI: state_nxt = YLO;
                YLO: begin
                    state_nxt = HDR;
                    if (!bad && ({1'b0, x_full} < H_LIM) && ({1'b0, y_full} < V_LIM))
                        commit = 1'b1;
                    else
                        err_inc = 1'b1;
                end
                default: state_nxt = HDR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= HDR;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we        <= 1'b0;
            wx        <= 10'd0;
            wy        <= 10'd0;
            brush     <= 1'b0;
            newColor  <= 3'd0;
            err_cnt   <= 8'd0;
            bit_cnt   <= 3'd0;
            shreg     <= 7'd0;
            hdr_brush <= 1'b0;
            hdr_color <= 3'd0;
            x_hi      <= 2'd0;
            x_lo      <= 8'd0;
            y_hi      <= 2'd0;
            bad       <= 1'b0;
        end else begin
            we <= commit;
            if (cs_rise) begin
                bit_cnt <= 3'd0;
            end else if (bit_en) begin
                bit_cnt <= bit_cnt + 3'd1;
                shreg   <= byte_in[6:0];
            end
            // Header fields are captured even for a rejected header; they are overwritten before use
            if (byte_done) begin
                case (state)
                    HDR: {hdr_brush, hdr_color, x_hi} <= byte_in[5:0];
                    XLO: x_lo <= byte_in;
                    YHI: begin
                        y_hi <= byte_in[1:0];
                        bad  <= |byte_in[7:2];
                    end
                    default: ;
                endcase
            end
            if (commit) begin
                wx       <= x_full;
                wy       <= y_full;
                brush    <= hdr_brush;
                newColor <= hdr_color;
            end
            if (err_inc && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
        end
    end
endmodule
